// File: rtl/bp_common_pkg.sv
// Shared definitions for the LTB trace tooling.
//
// Contents:
//   DECLARE_BP_LTB_TRACE_REC_S(vaddr_width_mp, ltb_cnt_width_mp)
//       Declares bp_ltb_trace_rec_s, the packed trace record shared by the
//       replayer, the profiler and trace-ROM generators.
//   BP_LTB_TRACE_REC_WIDTH(vaddr_width_mp, ltb_cnt_width_mp)
//       Width in bits of that record.
//   bp_common_pkg::bp_ltb_replay_state_e
//       State encoding of the trace replayer FSM.
//
// Record layout, MSB to LSB:
//   last, op (0 read / 1 write), addr, taken, conf, mispredict,
//   non_spec_cnt, trip_cnt
`ifndef BP_COMMON_PKG_SV
`define BP_COMMON_PKG_SV

`define DECLARE_BP_LTB_TRACE_REC_S(vaddr_width_mp, ltb_cnt_width_mp) \
    typedef struct packed { \
        logic                          last; \
        logic                          op; \
        logic [vaddr_width_mp-1:0]     addr; \
        logic                          taken; \
        logic                          conf; \
        logic                          mispredict; \
        logic [ltb_cnt_width_mp-1:0]   non_spec_cnt; \
        logic [ltb_cnt_width_mp-1:0]   trip_cnt; \
    } bp_ltb_trace_rec_s

// last + op + taken + conf + mispredict = 5 single-bit fields
`define BP_LTB_TRACE_REC_WIDTH(vaddr_width_mp, ltb_cnt_width_mp) \
    (5 + (vaddr_width_mp) + 2*(ltb_cnt_width_mp))

package bp_common_pkg;

    typedef enum logic [2:0] {
        e_init  = 3'd0,
        e_idle  = 3'd1,
        e_read  = 3'd2,
        e_check = 3'd3,
        e_write = 3'd4,
        e_done  = 3'd5
    } bp_ltb_replay_state_e;

    localparam logic bp_ltb_op_read  = 1'b0;
    localparam logic bp_ltb_op_write = 1'b1;

endpackage

`endif

// File: rtl/bp_ltb_sat_counter.sv
// Saturating up-counter used for the replayer statistics.
//
// Ports:
//   clk_i     clock, counts on posedge
//   reset_li  asynchronous active-low clear
//   en_i      increment request; ignored once the counter is all ones
//   count_o   current count, holds at 2^width_p-1
module bp_ltb_sat_counter #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_li,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            count_o <= '0;
        end else if (en_i && (count_o != {width_p{1'b1}})) begin
            count_o <= count_o + width_p'(1);
        end
    end

endmodule

// File: rtl/bsg_dff_en.sv
// Enabled D flip-flop bank. This local copy carries an asynchronous
// active-low clear so that a captured record disappears together with the
// FSM state when reset is asserted.
//
// Ports:
//   clk_i     clock
//   reset_li  asynchronous active-low clear
//   en_i      load enable
//   data_i    next value
//   data_o    registered value
module bsg_dff_en #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_li,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            data_o <= '0;
        end else if (en_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/bp_ltb_trace_replayer.sv
// Replays packed LTB trace records into an LTB's read and update ports and
// checks read predictions against the values stored in each read record.
//
// Handshakes: a record transfers on a cycle where rec_v_i & rec_ready_o;
// rec_v_i is ignored while rec_ready_o=0. An update is offered while w_v_o=1
// with all br_* fields stable and completes on the cycle w_yumi_i=1
// (w_yumi_i is ignored otherwise). r_v_o is a one-cycle request with no
// back-pressure; the prediction is sampled the following cycle.
//
// Ports:
//   clk_i, reset_li           clock; asynchronous active-low reset
//   init_done_i               LTB finished initialising
//   rec_v_i, rec_i, rec_ready_o   record stream input
//   r_v_o, r_addr_o           LTB read request
//   pred_*_i                  LTB prediction, checked one cycle after r_v_o
//   w_v_o, br_*_o, w_yumi_i   LTB update request
//   read_cnt_o, write_cnt_o, mismatch_cnt_o   saturating statistics
//   mismatch_v_o              registered pulse per failed check
//   first_mismatch_addr_o     PC of the first failed check since reset
//   done_o                    set once the record with last=1 retires
//   state_o                   current FSM state, for observation
module bp_ltb_trace_replayer
    import bp_common_pkg::*;
#(
    parameter int vaddr_width_p   = 39,
    parameter int ltb_cnt_width_p = 8,
    parameter int stat_width_p    = 32,
    localparam int rec_width_lp   = `BP_LTB_TRACE_REC_WIDTH(vaddr_width_p, ltb_cnt_width_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_li,
    input  logic                       init_done_i,

    input  logic                       rec_v_i,
    input  logic [rec_width_lp-1:0]    rec_i,
    output logic                       rec_ready_o,

    output logic                       r_v_o,
    output logic [vaddr_width_p-1:0]   r_addr_o,
    input  logic                       pred_v_i,
    input  logic                       pred_conf_i,
    input  logic                       pred_taken_i,
    input  logic [ltb_cnt_width_p-1:0] pred_non_spec_cnt_i,
    input  logic [ltb_cnt_width_p-1:0] pred_trip_cnt_i,

    output logic                       w_v_o,
    output logic [vaddr_width_p-1:0]   br_src_addr_o,
    output logic                       br_taken_o,
    output logic                       br_conf_o,
    output logic                       br_mispredict_o,
    output logic [ltb_cnt_width_p-1:0] br_non_spec_cnt_o,
    output logic [ltb_cnt_width_p-1:0] br_trip_cnt_o,
    input  logic                       w_yumi_i,

    output logic [stat_width_p-1:0]    read_cnt_o,
    output logic [stat_width_p-1:0]    write_cnt_o,
    output logic [stat_width_p-1:0]    mismatch_cnt_o,
    output logic                       mismatch_v_o,
    output logic [vaddr_width_p-1:0]   first_mismatch_addr_o,
    output logic                       done_o,
    output bp_ltb_replay_state_e       state_o
);

    `DECLARE_BP_LTB_TRACE_REC_S(vaddr_width_p, ltb_cnt_width_p);

    // op sits just below last at the top of the packed record
    localparam int op_bit_lp = rec_width_lp - 2;

    bp_ltb_replay_state_e state_r, state_n;
    bp_ltb_trace_rec_s    rec_r;

    logic rec_en;
    logic read_en;
    logic write_en;
    logic mismatch_n;
    logic rec_ready;
    logic r_v;
    logic w_v;

    logic                     mismatch_v_r;
    logic                     mismatch_seen_r;
    logic [vaddr_width_p-1:0] first_mismatch_addr_r;

    bsg_dff_en #(
        .width_p (rec_width_lp)
    ) rec_reg (
        .clk_i    (clk_i),
        .reset_li (reset_li),
        .en_i     (rec_en),
        .data_i   (rec_i),
        .data_o   (rec_r)
    );

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            state_r <= e_init;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n    = state_r;
        rec_ready  = 1'b0;
        r_v        = 1'b0;
        w_v        = 1'b0;
        rec_en     = 1'b0;
        read_en    = 1'b0;
        write_en   = 1'b0;
        mismatch_n = 1'b0;

        case (state_r)
            e_init: begin
                if (init_done_i) begin
                    state_n = e_idle;
                end
            end

            e_idle: begin
                rec_ready = 1'b1;
                if (rec_v_i) begin
                    rec_en  = 1'b1;
                    state_n = (rec_i[op_bit_lp] == bp_ltb_op_write) ? e_write : e_read;
                end
            end

            e_read: begin
                r_v     = 1'b1;
                state_n = e_check;
            end

            e_check: begin
                read_en    = 1'b1;
                mismatch_n = !pred_v_i
                          || (pred_taken_i        != rec_r.taken)
                          || (pred_conf_i         != rec_r.conf)
                          || (pred_non_spec_cnt_i != rec_r.non_spec_cnt)
                          || (pred_trip_cnt_i     != rec_r.trip_cnt);
                state_n    = rec_r.last ? e_done : e_idle;
            end

            e_write: begin
                w_v = 1'b1;
                if (w_yumi_i) begin
                    write_en = 1'b1;
                    state_n  = rec_r.last ? e_done : e_idle;
                end
            end

            e_done: begin
                state_n = e_done;
            end

            default: begin
                state_n = e_init;
            end
        endcase
    end

    // Pulse is registered so it lines up with the counter update; the first
    // failing PC is captured once and then frozen until reset.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            mismatch_v_r          <= 1'b0;
            mismatch_seen_r       <= 1'b0;
            first_mismatch_addr_r <= '0;
        end else begin
            mismatch_v_r <= mismatch_n;
            if (mismatch_n && !mismatch_seen_r) begin
                mismatch_seen_r       <= 1'b1;
                first_mismatch_addr_r <= rec_r.addr;
            end
        end
    end

    bp_ltb_sat_counter #(.width_p(stat_width_p)) read_counter (
        .clk_i    (clk_i),
        .reset_li (reset_li),
        .en_i     (read_en),
        .count_o  (read_cnt_o)
    );

    bp_ltb_sat_counter #(.width_p(stat_width_p)) write_counter (
        .clk_i    (clk_i),
        .reset_li (reset_li),
        .en_i     (write_en),
        .count_o  (write_cnt_o)
    );

    bp_ltb_sat_counter #(.width_p(stat_width_p)) mismatch_counter (
        .clk_i    (clk_i),
        .reset_li (reset_li),
        .en_i     (mismatch_n),
        .count_o  (mismatch_cnt_o)
    );

    // Data outputs always reflect rec_r; only the valids qualify them.
    assign rec_ready_o           = rec_ready;
    assign r_v_o                 = r_v;
    assign r_addr_o              = rec_r.addr;
    assign w_v_o                 = w_v;
    assign br_src_addr_o         = rec_r.addr;
    assign br_taken_o            = rec_r.taken;
    assign br_conf_o             = rec_r.conf;
    assign br_mispredict_o       = rec_r.mispredict;
    assign br_non_spec_cnt_o     = rec_r.non_spec_cnt;
    assign br_trip_cnt_o         = rec_r.trip_cnt;
    assign mismatch_v_o          = mismatch_v_r;
    assign first_mismatch_addr_o = first_mismatch_addr_r;
    assign done_o                = (state_r == e_done);
    assign state_o               = state_r;

endmodule

// File: doc/bp_ltb_trace_replayer.md
# bp_ltb_trace_replayer

Replays a packed stream of loop-termination-buffer (LTB) trace records into an LTB instance's read and write ports. For read records it checks the synchronous prediction against the expected values in the record. It counts reads, writes and prediction mismatches. It sits in the BE/FE testbench harness between a record source (ROM or DMA-fed FIFO) and the LTB under test, as the stimulus/checker counterpart of the LTB trace profiler.

## Interface
- vaddr_width_p, 39, virtual address width of branch source PC
- ltb_cnt_width_p, 8, width of speculative/non-speculative/trip counters
- stat_width_p, 32, width of statistic counters
- clk_i  in  1  clock; all state updates on posedge
- reset_li  in  1  reset, asynchronous, active-low
- init_done_i  in  1  LTB initialization complete
- rec_v_i  in  1  trace record valid
- rec_i  in  bp_ltb_trace_rec_width  packed bp_ltb_trace_rec_s
- rec_ready_o  out  1  record accepted this cycle when rec_v_i & rec_ready_o
- r_v_o  out  1  LTB read request
- r_addr_o  out  vaddr_width_p  LTB read PC
- pred_v_i, pred_conf_i, pred_taken_i  in  1 each  LTB prediction, valid one cycle after r_v_o
- pred_non_spec_cnt_i, pred_trip_cnt_i  in  ltb_cnt_width_p  LTB prediction counters
- w_v_o  out  1  LTB update request
- br_src_addr_o  out  vaddr_width_p  update PC
- br_taken_o, br_conf_o, br_mispredict_o  out  1 each  update fields
- br_non_spec_cnt_o, br_trip_cnt_o  out  ltb_cnt_width_p  update counters
- w_yumi_i  in  1  LTB consumed the update
- read_cnt_o, write_cnt_o, mismatch_cnt_o  out  stat_width_p  statistics
- mismatch_v_o  out  1  one-cycle pulse when a prediction check fails
- first_mismatch_addr_o  out  vaddr_width_p  PC of the first failing read
- done_o  out  1  sticky; set after the record with last=1 retires

## Operation
- Record fields, MSB to LSB: last, op (0 read, 1 write), addr, taken, conf, mispredict, non_spec_cnt, trip_cnt. On reads, taken/conf/non_spec/trip are expected values and mispredict is ignored.
- FSM states are e_init, e_idle, e_read, e_check, e_write and e_done. Reset enters e_init.
- e_init: rec_ready_o=0. Go to e_idle when init_done_i=1.
- e_idle: rec_ready_o=1. On handshake, capture rec_i into rec_r. Go to e_read if op=0, otherwise e_write.
- e_read: r_v_o=1 and r_addr_o=rec_r.addr for exactly one cycle. Go to e_check.
- e_check: sample the pred_* inputs. A mismatch occurs if any of the following holds:
  - pred_v_i=0
  - taken differs from the expected value
  - conf differs from the expected value
  - non_spec_cnt differs from the expected value
  - trip_cnt differs from the expected value
- On a mismatch in e_check: pulse mismatch_v_o next cycle (registered) and increment mismatch_cnt_o. If this is the first mismatch since reset, latch first_mismatch_addr_o.
- On every e_check, increment read_cnt_o.
- Leaving e_check: go to e_done if rec_r.last, otherwise e_idle.
- e_write: w_v_o=1 and the br_* outputs are driven from rec_r, held stable until w_yumi_i. On w_yumi_i, increment write_cnt_o and go to e_done if last, otherwise e_idle.
- e_done: done_o=1, rec_ready_o=0. This is terminal until reset.
- All statistic counters saturate at 2^stat_width_p-1 and do not wrap.
- The br_* and r_addr_o outputs are driven from rec_r at all times. Only the valids gate them.

## Timing
- Reset values:
  - State is e_init.
  - All counters, done_o, mismatch_v_o, first_mismatch_addr_o and rec_r are 0.
  - Therefore every output is 0.
- Reset is asynchronous assert. Deassertion is synchronized by the harness. Reset mid-write drops w_v_o immediately, and the in-flight record is lost.
- Read latency:
  - Handshake is at cycle N.
  - r_v_o is asserted at N+1.
  - The prediction is sampled at N+2.
  - mismatch_v_o and the counters update at N+3.
- Read throughput is one record per 3 cycles.
- Write latency: handshake at N, w_v_o asserted from N+1. A w_yumi_i arriving in the same cycle as first w_v_o is legal, giving 2 cycles per write minimum.
- w_yumi_i is ignored outside e_write.
- pred_* inputs are ignored outside e_check.
- rec_v_i is ignored when rec_ready_o=0.
- A record with last=1 that is the very first record still issues fully before done_o.
- A mismatch and counter saturation in the same cycle: the pulse still fires, and the counter holds its maximum.

## Structure
- bp_ltb_trace_rec_s and the FSM enum bp_ltb_replay_state_e belong in bp_common_pkg, in a macro declare_bp_ltb_trace_rec_s(vaddr_width_p, ltb_cnt_width_p) with a matching width macro. This lets the profiler and any trace-ROM generator share the record layout.
- One sub-module, bp_ltb_sat_counter (parameterized width, en_i, saturating), instantiated three times for the statistics.
- rec_r uses bsg_dff_en. The state register is an always_ff with async negedge reset_li.

## Test plan
- Reset/init: hold init_done_i=0 for 10 cycles with rec_v_i=1 → rec_ready_o=0, all outputs 0. Raise init_done_i → rec_ready_o=1 next cycle.
- Matching read: record {last=0, read, addr=0x80000040, taken=1, conf=1, ns=3, trip=5} with the LTB model returning the same values → r_v_o one cycle at N+1 with addr 0x80000040, read_cnt_o=1, mismatch_cnt_o=0.
- Mismatching read: expected trip=5, model returns trip=4 → mismatch_v_o pulse at N+3, mismatch_cnt_o=1, first_mismatch_addr_o=addr. A second mismatch at 0x100 leaves first_mismatch_addr_o unchanged.
- Write backpressure: write record addr=0x1000, ns=7, trip=9 with w_yumi_i held low for 4 cycles → w_v_o and the fields stable for 5 cycles, write_cnt_o=1 after yumi.
- Last record: sequence read, write, read(last=1) → done_o rises after the final check, rec_ready_o=0 thereafter, read_cnt_o=2, write_cnt_o=1.
- Async reset mid-write: drop reset_li while w_v_o=1 → w_v_o=0 and all counters 0 without a clock edge.
